// File: rtl/baud_cfg_ctrl.sv
// Baud generator configuration controller: derives baud_freq/baud_limit from
// clk_hz and baud_hz using a Stein GCD and a shared restoring divider.
module baud_cfg_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] clk_hz,
  input  logic [23:0] baud_hz,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [11:0] baud_freq,
  output logic [15:0] baud_limit,
  output logic        gen_clear
);

  // Handshake: start is taken only in IDLE; busy is high from the accepting
  // edge until the edge that raises the one-cycle done pulse. A start seen
  // while busy is dropped, not queued.
  typedef enum logic [2:0] {IDLE, GCD, DIV_Q, DIV_F, CHECK} state_t;

  state_t      state;
  logic [31:0] clk_l, bd_l;
  logic [31:0] a, b, g;
  logic [31:0] rem, dvd, quot, q_res;
  logic [4:0]  k;
  logic [4:0]  cnt;
  logic        zero_op;

  logic [32:0] trial;
  logic        fits;
  logic [31:0] diff;
  logic [31:0] rem_next, quot_next;
  logic [31:0] lim;
  logic        chk_err;

  // One restoring step; the 33-bit trial keeps the shifted remainder exact.
  assign trial     = {rem, dvd[31]};
  assign fits      = trial >= {1'b0, g};
  assign diff      = trial[31:0] - g;
  assign rem_next  = fits ? diff : trial[31:0];
  assign quot_next = {quot[30:0], fits};

  // In CHECK, q_res holds clk/g and quot holds (16*baud)/g.
  assign lim     = q_res - quot;
  assign chk_err = zero_op || (quot > 32'd4095) || (q_res <= quot) ||
                   (lim > 32'd65535);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      gen_clear  <= 1'b0;
      baud_freq  <= 12'd576;
      baud_limit <= 16'd15049;
      clk_l      <= '0;
      bd_l       <= '0;
      a          <= '0;
      b          <= '0;
      g          <= '0;
      rem        <= '0;
      dvd        <= '0;
      quot       <= '0;
      q_res      <= '0;
      k          <= '0;
      cnt        <= '0;
      zero_op    <= 1'b0;
    end else begin
      done      <= 1'b0;
      gen_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            clk_l   <= clk_hz;
            bd_l    <= {4'b0, baud_hz, 4'b0};
            a       <= clk_hz;
            b       <= {4'b0, baud_hz, 4'b0};
            k       <= '0;
            error   <= 1'b0;
            busy    <= 1'b1;
            zero_op <= (clk_hz == 32'd0) || (baud_hz == 24'd0);
            state   <= ((clk_hz == 32'd0) || (baud_hz == 24'd0)) ? CHECK : GCD;
          end
        end
        GCD: begin
          if ((a == 32'd0) || (b == 32'd0)) begin
            g     <= (a | b) << k;
            rem   <= '0;
            quot  <= '0;
            dvd   <= clk_l;
            cnt   <= '0;
            state <= DIV_Q;
          end else if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 5'd1;
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a >= b) begin
            a <= a - b;
          end else begin
            b <= b - a;
          end
        end
        DIV_Q: begin
          rem  <= rem_next;
          quot <= quot_next;
          dvd  <= dvd << 1;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            q_res <= quot_next;
            rem   <= '0;
            quot  <= '0;
            dvd   <= bd_l;
            state <= DIV_F;
          end
        end
        DIV_F: begin
          rem  <= rem_next;
          quot <= quot_next;
          dvd  <= dvd << 1;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) state <= CHECK;
        end
        CHECK: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          error <= chk_err;
          // Both divider settings move together with gen_clear, never apart.
          if (!chk_err) begin
            baud_freq  <= quot[11:0];
            baud_limit <= lim[15:0];
            gen_clear  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Bench for baud_cfg_ctrl: directed cases from the baud table plus randomized
// requests checked against an arithmetic GCD/divide reference model.
module tb_baud_cfg_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] clk_hz;
  logic [23:0] baud_hz;
  logic        busy, done, error, gen_clear;
  logic [11:0] baud_freq;
  logic [15:0] baud_limit;

  int n_checks = 0;
  int n_fail   = 0;

  logic [28:0] exp_q[$];
  logic [11:0] mdl_freq;
  logic [15:0] mdl_limit;

  baud_cfg_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .clk_hz     (clk_hz),
    .baud_hz    (baud_hz),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .baud_freq  (baud_freq),
    .baud_limit (baud_limit),
    .gen_clear  (gen_clear)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: Euclid gcd, then plain division and the range rules.
  task automatic model_req(input logic [31:0] c, input logic [23:0] bd);
    longint unsigned x, y, t, g, q, f, l;
    logic err;
    x = c;
    y = longint'(bd) * 16;
    if (x == 0 || y == 0) begin
      err = 1'b1;
    end else begin
      while (y != 0) begin
        t = x % y;
        x = y;
        y = t;
      end
      g = x;
      q = longint'(c) / g;
      f = (longint'(bd) * 16) / g;
      l = q - f;
      err = (f > 4095) || (q <= f) || (l > 65535);
      if (!err) begin
        mdl_freq  = 12'(f);
        mdl_limit = 16'(l);
      end
    end
    exp_q.push_back({err, mdl_freq, mdl_limit});
  endtask

  task automatic run_req(input logic [31:0] c, input logic [23:0] bd, input int ignore_at);
    logic [28:0] e;
    int n, gap, gens, extra;
    logic zero_path;
    zero_path = (c == 0) || (bd == 0);
    model_req(c, bd);
    clk_hz  = c;
    baud_hz = bd;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    clk_hz  = $urandom;
    baud_hz = 24'($urandom);
    check("busy_rise", {31'b0, busy}, 1);
    n = 1; gap = 0; gens = 0;
    while (!done && n < 250) begin
      if (!busy) gap++;
      start = (n == ignore_at);
      tick();
      start = 1'b0;
      n++;
      if (gen_clear) gens++;
    end
    check("done_seen", {31'b0, done}, 1);
    e = exp_q.pop_front();
    check("error", {31'b0, error}, {31'b0, e[28]});
    check("baud_freq", {20'b0, baud_freq}, {20'b0, e[27:16]});
    check("baud_limit", {16'b0, baud_limit}, {16'b0, e[15:0]});
    check("gen_clear_at_done", {31'b0, gen_clear}, {31'b0, !e[28]});
    check("gen_clear_count", gens, e[28] ? 0 : 1);
    check("busy_fall", {31'b0, busy}, 0);
    check("busy_gap", gap, 0);
    if (zero_path) check("zero_latency", n, 2);
    else           check("latency_bound", {31'b0, (n <= 194)}, 1);
    extra = 0;
    repeat (4) begin
      tick();
      if (done || busy || gen_clear) extra++;
    end
    check("no_extra_activity", extra, 0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_busy"}, {31'b0, busy}, 0);
    check({pfx, "_done"}, {31'b0, done}, 0);
    check({pfx, "_error"}, {31'b0, error}, 0);
    check({pfx, "_gen_clear"}, {31'b0, gen_clear}, 0);
    check({pfx, "_freq"}, {20'b0, baud_freq}, 576);
    check({pfx, "_limit"}, {16'b0, baud_limit}, 15049);
  endtask

  initial begin
    int dones;
    int mode;
    logic [31:0] rc;
    logic [23:0] rb;
    logic [31:0] clk_tab[4];
    logic [23:0] baud_tab[6];
    clk_tab  = '{32'd50_000_000, 32'd100_000_000, 32'd48_000_000, 32'd18_432_000};
    baud_tab = '{24'd9600, 24'd19200, 24'd38400, 24'd57600, 24'd115200, 24'd1200};

    reset = 1'b1; start = 1'b0; clk_hz = '0; baud_hz = '0;
    mdl_freq = 12'd576; mdl_limit = 16'd15049;
    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    run_req(32'd50_000_000, 24'd115200, 0);
    run_req(32'd50_000_000, 24'd3_125_000, 0);
    run_req(32'd100_000_000, 24'd9600, 0);
    run_req(32'd50_000_001, 24'd115200, 0);
    run_req(32'd50_000_000, 24'd115200, 0);
    run_req(32'd50_000_000, 24'd0, 0);
    run_req(32'd0, 24'd9600, 0);
    run_req(32'd100_000_000, 24'd19200, 20);

    // Reset while the GCD is stepping.
    clk_hz = 32'd50_000_000; baud_hz = 24'd115200; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    mdl_freq = 12'd576; mdl_limit = 16'd15049;
    tick();
    reset = 1'b0;
    dones = 0;
    repeat (200) begin
      tick();
      if (done || busy) dones++;
    end
    check("midreset_no_done", dones, 0);
    run_req(32'd100_000_000, 24'd9600, 0);

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          rc = $urandom;
          rb = 24'($urandom);
        end
        1: begin
          rc = clk_tab[$urandom_range(0, 3)];
          rb = baud_tab[$urandom_range(0, 5)];
        end
        2: begin
          rb = 24'($urandom_range(1, 60000));
          rc = 32'(rb) * 32'd16 * 32'($urandom_range(2, 4000)) + 32'($urandom_range(0, 3));
        end
        default: begin
          rc = 32'($urandom_range(1, 300_000_000));
          rb = 24'($urandom_range(0, 2_000_000));
        end
      endcase
      run_req(rc, rb, $urandom_range(0, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_cfg_ctrl.md
# baud_cfg_ctrl

Sequential configuration controller for the UART baud generator. From a system clock frequency and a requested baud rate, it computes the two divider settings: baud_freq = 16·baud / gcd(clk, 16·baud) and baud_limit = clk / gcd − baud_freq. It range-checks both values and loads them into the baud generator atomically. It sits between the register file (start, clk_hz, baud_hz) and the baud generator's baud_freq/baud_limit/reset inputs.

## Interface
- No parameters; widths are fixed to match the baud generator (12-bit freq, 16-bit limit).
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request; honoured only in IDLE
- clk_hz  in  32  system clock frequency in Hz; sampled on accepted start
- baud_hz  in  24  requested baud rate; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at the end of every accepted request
- error  out  1  sticky; valid with done, cleared on the next accepted start
- baud_freq  out  12  drives the baud generator's baud_freq input
- baud_limit  out  16  drives the baud generator's baud_limit input
- gen_clear  out  1  one-cycle pulse that restarts the baud generator counter (ORed into its reset by the integrator)

## Operation
- States: IDLE → GCD → DIV_Q → DIV_F → CHECK → IDLE.
- IDLE + start:
  - latch a = clk_hz and b = baud_hz<<4 (28 bits, zero-extended to 32); clear error.
  - If either operand is 0, go directly to CHECK with the error flag set.
- GCD uses binary Stein's algorithm, one step per cycle:
  - both even: shift both right, k++.
  - a even: a>>=1. b even: b>>=1.
  - both odd: the larger operand becomes the difference.
  - Exit when a==0 or b==0; then g = (a|b)<<k.
- DIV_Q: restoring divide q = clk_hz / g, 32 iterations (32 cycles).
- DIV_F: restoring divide f = (baud_hz<<4) / g, 32 iterations, reusing the same divider datapath. The remainder is always 0 by construction.
- CHECK (1 cycle):
  - lim = q − f, computed in 32 bits.
  - error if f > 4095, or q ≤ f (lim = 0, i.e. clk_hz ≤ 16·baud_hz), or lim > 65535, or the zero-operand flag is set.
  - On success: baud_freq ← f[11:0], baud_limit ← lim[15:0], gen_clear = 1.
  - On error: baud_freq and baud_limit keep their previous values and gen_clear stays 0.
  - In both cases: done = 1, then go to IDLE.
- start while busy is ignored and not queued.
- Latched operands are insensitive to clk_hz/baud_hz changes after start.

## Timing
- Reset values:
  - state IDLE; busy 0, done 0, error 0, gen_clear 0.
  - baud_freq = 12'd576, baud_limit = 16'd15049 (115200 baud at 50 MHz).
- busy rises on the clock edge that accepts start and falls on the edge on which done is asserted.
- baud_freq, baud_limit, done and gen_clear all update on the same edge. The baud generator never sees a mixed old/new pair.
- Latency from start to done is at most 1 + 128 (GCD) + 32 + 32 + 1 = 194 cycles; the zero-operand path takes 2 cycles.
- Back-to-back requests: start in the cycle after done is accepted.
- Reset mid-operation: outputs return to their reset values immediately, no done pulse is issued, and the partial result is discarded.
- Arithmetic:
  - all intermediate values are unsigned 32-bit.
  - k ≤ 31.
  - the divider compares a 33-bit partial remainder to avoid overflow.

## Test plan
- Nominal, 50 MHz: clk_hz=50_000_000, baud_hz=115200 → g=3200, done with error=0, baud_freq=576, baud_limit=15049, gen_clear pulses once in the done cycle.
- Nominal, 100 MHz: clk_hz=100_000_000, baud_hz=9600 → baud_freq=24, baud_limit=15601; busy held continuously and done within 194 cycles.
- Limit zero: clk_hz=50_000_000, baud_hz=3_125_000 → error=1, outputs keep their prior values (576/15049), no gen_clear.
- Range overflow: clk_hz=50_000_001, baud_hz=115200 → g=3, f=614400 > 4095 → error=1, outputs unchanged. Then a valid start clears error.
- Zero operand and busy handling: baud_hz=0 → done with error=1 two cycles after start. Pulse start again mid-computation of a valid request → ignored, exactly one done pulse.
- Reset mid-GCD: assert reset during busy → busy=0, outputs at reset values, no done pulse. A subsequent valid request completes normally.
